// File: rtl/mdr_pkg.sv
// Shared types and defaults for the memory data register port.
package mdr_pkg;

  localparam int MDR_DATA_W = 32;
  localparam int MDR_ADDR_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mdr_timeout_ctr.sv
// Watchdog counter for a pending memory request.
// Used by mdr_mem_port only when MDR_TIMEOUT_EN is defined.
module mdr_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic clear,
  input  logic start,
  input  logic tick,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mdr_mem_port.sv
// Memory data register with a req/ack memory handshake.
// Optional request watchdog enabled by defining MDR_TIMEOUT_EN.
module mdr_mem_port
  import mdr_pkg::*;
#(
  parameter int DATA_W      = MDR_DATA_W,
  parameter int ADDR_W      = MDR_ADDR_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] mar_q,
  input  logic              mdr_in,
  input  logic              mdr_out,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] bus_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t            r_state;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd;
  logic              r_wr;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic w_rd_go;
  logic w_wr_go;
  logic w_expired;

  assign w_rd_go = read & ~write;
  assign w_wr_go = write & ~read;

`ifdef MDR_TIMEOUT_EN
  logic w_start;
  logic w_tick;

  assign w_start = (r_state == IDLE) & (w_rd_go | w_wr_go);
  assign w_tick  = ((r_state == RD_REQ) | (r_state == WR_REQ))
                 & ~mem_ack;

  mdr_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .clear  (clear),
    .start  (w_start),
    .tick   (w_tick),
    .expired(w_expired)
  );
`else
  // No watchdog: a request waits for ack forever.
  assign w_expired = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_mdr   <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (mdr_in) r_mdr <= bus_in;
          if (w_rd_go) begin
            r_state <= RD_REQ;
            r_addr  <= mar_q;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_wr_go) begin
            // A same-cycle load is sent by the write.
            r_state <= WR_REQ;
            r_addr  <= mar_q;
            r_wr    <= 1'b1;
            r_busy  <= 1'b1;
            r_wdata <= mdr_in ? bus_in : r_mdr;
          end
        end
        RD_REQ: begin
          if (mem_ack | w_expired) begin
            if (mem_ack) r_mdr <= mem_rdata;
            r_err   <= ~mem_ack;
            r_done  <= 1'b1;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        WR_REQ: begin
          if (mem_ack | w_expired) begin
            r_err   <= ~mem_ack;
            r_done  <= 1'b1;
            r_wr    <= 1'b0;
            r_busy  <= 1'b0;
            r_wdata <= '0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_out   = {DATA_W{mdr_out}} & r_mdr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_addr  = r_addr;
  assign mem_rd    = r_rd;
  assign mem_wr    = r_wr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Scoreboard bench for mdr_mem_port.
// Timeout scenario is built only with MDR_TIMEOUT_EN.
module tb_mdr_mem_port;

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] bus_in;
  logic [8:0]  mar_q;
  logic        mdr_in, mdr_out, read, write;
  logic [31:0] bus_out;
  logic        busy, done, err;
  logic [8:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mdr_mem_port dut (
    .clk      (clk),
    .clear    (clear),
    .bus_in   (bus_in),
    .mar_q    (mar_q),
    .mdr_in   (mdr_in),
    .mdr_out  (mdr_out),
    .read     (read),
    .write    (write),
    .bus_out  (bus_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    bus_in = v;
    mdr_in = 1'b1;
    tick();
    mdr_in = 1'b0;
  endtask

  task automatic run_xact(input logic wr, input logic [8:0] addr,
                          input logic [31:0] data, input int dly);
    exp_t e;
    int hi;
    logic [31:0] wd;
    logic got;
    e.wr = wr; e.addr = addr; e.data = data;
    sb.push_back(e);
    mar_q = addr; read = ~wr; write = wr;
    tick();
    read = 1'b0; write = 1'b0;
    hi = 0; wd = '0;
    for (int i = 1; i <= dly; i++) begin
      if ((wr ? mem_wr : mem_rd) === 1'b1 && busy === 1'b1) hi++;
      if (wr) wd = mem_wdata;
      if (i == dly) begin
        mem_ack = 1'b1;
        mem_rdata = wr ? 32'hFFFF_FFFF : data;
      end
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
    end
    total++;
    if (hi !== dly) begin
      bad++;
      $display("FAIL req_cycles got=%0d exp=%0d", hi, dly);
    end
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (done === 1'b1) got = 1'b1;
      else tick();
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_wait got=0 exp=1");
    end
    e = sb.pop_front();
    total++;
    if (mem_addr !== e.addr) begin
      bad++;
      $display("FAIL mem_addr got=%h exp=%h", mem_addr, e.addr);
    end
    total++;
    if ({mem_rd, mem_wr, busy, err} !== 4'b0) begin
      bad++;
      $display("FAIL req_drop got=%b exp=0000",
               {mem_rd, mem_wr, busy, err});
    end
    total++;
    if (e.wr) begin
      if (wd !== e.data) begin
        bad++;
        $display("FAIL wdata got=%h exp=%h", wd, e.data);
      end
    end else begin
      mdr_out = 1'b1;
      #1;
      if (bus_out !== e.data) begin
        bad++;
        $display("FAIL rd_mdr got=%h exp=%h", bus_out, e.data);
      end
      mdr_out = 1'b0;
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_reset();
    clear = 1'b0;
    bus_in = '0; mar_q = '0; mdr_in = 0; mdr_out = 1'b1;
    read = 0; write = 0; mem_rdata = '0; mem_ack = 0;
    tick(); tick();
    total++;
    if ({busy, done, err, mem_rd, mem_wr} !== 5'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=00000",
               {busy, done, err, mem_rd, mem_wr});
    end
    total++;
    if ({mem_addr, mem_wdata, bus_out} !== '0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h/%h exp=0",
               mem_addr, mem_wdata, bus_out);
    end
    mdr_out = 1'b0;
    clear = 1'b1;
    tick();
  endtask

  task automatic test_load_drive();
    load_mdr(32'hA5A5_0F0F);
    mdr_out = 1'b1;
    #1;
    total++;
    if (bus_out !== 32'hA5A5_0F0F) begin
      bad++;
      $display("FAIL drive_on got=%h exp=a5a50f0f", bus_out);
    end
    mdr_out = 1'b0;
    #1;
    total++;
    if (bus_out !== 32'h0) begin
      bad++;
      $display("FAIL drive_off got=%h exp=0", bus_out);
    end
  endtask

  task automatic test_read();
    run_xact(1'b0, 9'h012, 32'hDEAD_BEEF, 2);
  endtask

  task automatic test_write();
    load_mdr(32'h1234_5678);
    run_xact(1'b1, 9'h1FF, 32'h1234_5678, 4);
    mdr_out = 1'b1;
    #1;
    total++;
    if ({mem_wdata, bus_out} !== {32'h0, 32'h1234_5678}) begin
      bad++;
      $display("FAIL wr_after got=%h/%h exp=0/12345678",
               mem_wdata, bus_out);
    end
    mdr_out = 1'b0;
  endtask

  task automatic test_conflict();
    mar_q = 9'h0AA; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    total++;
    if ({mem_rd, mem_wr, busy} !== 3'b0) begin
      bad++;
      $display("FAIL conflict got=%b exp=000", {mem_rd, mem_wr, busy});
    end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    mdr_out = 1'b1;
    #1;
    total++;
    if ({done, bus_out} !== {1'b0, 32'h1234_5678}) begin
      bad++;
      $display("FAIL idle_ack got=%b/%h exp=0/12345678", done, bus_out);
    end
    mdr_out = 1'b0;
  endtask

  task automatic test_ignore();
    mar_q = 9'h033; read = 1'b1;
    tick();
    read = 1'b0;
    bus_in = 32'h0BAD_0BAD; mdr_in = 1'b1; write = 1'b1;
    tick();
    mdr_in = 1'b0; write = 1'b0;
    mdr_out = 1'b1;
    #1;
    total++;
    if ({mem_rd, mem_wr, bus_out} !== {2'b10, 32'h1234_5678}) begin
      bad++;
      $display("FAIL busy_ignore got=%b%b/%h exp=10/12345678",
               mem_rd, mem_wr, bus_out);
    end
    mdr_out = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0F0F_1234;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL ignore_done got=%b exp=1", done);
    end
    tick();
    mdr_out = 1'b1;
    #1;
    total++;
    if (bus_out !== 32'h0F0F_1234) begin
      bad++;
      $display("FAIL ignore_mdr got=%h exp=0f0f1234", bus_out);
    end
    mdr_out = 1'b0;
  endtask

  task automatic test_load_write_same();
    bus_in = 32'hCAFE_F00D; mdr_in = 1'b1;
    mar_q = 9'h077; write = 1'b1;
    tick();
    mdr_in = 1'b0; write = 1'b0;
    total++;
    if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 9'h077, 32'hCAFE_F00D}) begin
      bad++;
      $display("FAIL ld_wr got=%b/%h/%h exp=1/077/cafef00d",
               mem_wr, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    total++;
    if ({done, mem_wr} !== 2'b10) begin
      bad++;
      $display("FAIL ld_wr_done got=%b exp=10", {done, mem_wr});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    run_xact(1'b0, 9'h100, 32'h1111_2222, 1);
    run_xact(1'b1, 9'h101, 32'h1111_2222, 1);
    run_xact(1'b0, 9'h102, 32'h3333_4444, 3);
  endtask

  task automatic test_reset_mid_read();
    mar_q = 9'h044; read = 1'b1;
    tick();
    read = 1'b0;
    total++;
    if (mem_rd !== 1'b1) begin
      bad++;
      $display("FAIL mid_rd_pre got=%b exp=1", mem_rd);
    end
    #2;
    clear = 1'b0;
    mdr_out = 1'b1;
    #1;
    total++;
    if ({mem_rd, busy, mem_addr, bus_out} !== '0) begin
      bad++;
      $display("FAIL mid_rst got=%b%b/%h/%h exp=0",
               mem_rd, busy, mem_addr, bus_out);
    end
    mdr_out = 1'b0;
    tick();
    clear = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    total++;
    if ({mem_rd, busy, done} !== 3'b0) begin
      bad++;
      $display("FAIL mid_idle got=%b exp=000", {mem_rd, busy, done});
    end
  endtask

`ifdef MDR_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    load_mdr(32'h7777_8888);
    mar_q = 9'h005; read = 1'b1;
    tick();
    read = 1'b0;
    n = 0;
    while (mem_rd === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    total++;
    if (n !== 16) begin
      bad++;
      $display("FAIL to_cycles got=%0d exp=16", n);
    end
    mdr_out = 1'b1;
    #1;
    total++;
    if ({err, done, bus_out} !== {2'b11, 32'h7777_8888}) begin
      bad++;
      $display("FAIL to_err got=%b%b/%h exp=11/77778888",
               err, done, bus_out);
    end
    mdr_out = 1'b0;
    tick();
    total++;
    if ({err, done} !== 2'b00) begin
      bad++;
      $display("FAIL to_pulse got=%b exp=00", {err, done});
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    test_reset();
    test_load_drive();
    test_read();
    test_write();
    test_conflict();
    test_ignore();
    test_load_write_same();
    test_back_to_back();
    test_reset_mid_read();
`ifdef MDR_TIMEOUT_EN
    test_timeout();
`endif
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_left got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
